// File: rtl/bf_pkg.sv
// Shared beamformer constants: operand format, saturation limits and the
// sequencing states used by the transmit splitter and receive combiner.
package bf_pkg;

  localparam int DW      = 18;
  localparam int FRAC    = 17;
  localparam int SAT_MAX = (1 << (DW - 1)) - 1;
  localparam int SAT_MIN = -(1 << (DW - 1));

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CH0  = 3'd1,
    CH1  = 3'd2,
    CH2  = 3'd3,
    CH3  = 3'd4,
    DONE = 3'd5
  } bf_state_e;

endpackage

// File: rtl/cmul_sat.sv
// Combinational complex multiply y = a * b, full-precision products,
// arithmetic right shift by FRAC (floor) and saturation back to DW bits.
module cmul_sat #(
  parameter int DW   = bf_pkg::DW,
  parameter int FRAC = bf_pkg::FRAC
) (
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] a_q,
  input  logic signed [DW-1:0] b_i,
  input  logic signed [DW-1:0] b_q,
  output logic signed [DW-1:0] y_i,
  output logic signed [DW-1:0] y_q
);

  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW + 1;
  localparam logic signed [SW-1:0] Y_MAX = SW'((longint'(1) <<< (DW - 1)) - 1);
  localparam logic signed [SW-1:0] Y_MIN = SW'(-(longint'(1) <<< (DW - 1)));

  // Operands are sign-extended to PW bits; the low PW bits of that product
  // equal the exact signed product because it always fits in PW bits.
  logic [PW-1:0] p_ii, p_qq, p_iq, p_qi;
  assign p_ii = {{DW{a_i[DW-1]}}, a_i} * {{DW{b_i[DW-1]}}, b_i};
  assign p_qq = {{DW{a_q[DW-1]}}, a_q} * {{DW{b_q[DW-1]}}, b_q};
  assign p_iq = {{DW{a_i[DW-1]}}, a_i} * {{DW{b_q[DW-1]}}, b_q};
  assign p_qi = {{DW{a_q[DW-1]}}, a_q} * {{DW{b_i[DW-1]}}, b_i};

  logic signed [SW-1:0] re_full, im_full, re_sh, im_sh;
  assign re_full = $signed({p_ii[PW-1], p_ii}) - $signed({p_qq[PW-1], p_qq});
  assign im_full = $signed({p_iq[PW-1], p_iq}) + $signed({p_qi[PW-1], p_qi});
  assign re_sh   = re_full >>> FRAC;
  assign im_sh   = im_full >>> FRAC;

  // Clamp both rails to the DW-bit signed range.
  always_comb begin
    y_i = re_sh[DW-1:0];
    y_q = im_sh[DW-1:0];
    if (re_sh > Y_MAX)      y_i = Y_MAX[DW-1:0];
    else if (re_sh < Y_MIN) y_i = Y_MIN[DW-1:0];
    if (im_sh > Y_MAX)      y_q = Y_MAX[DW-1:0];
    else if (im_sh < Y_MIN) y_q = Y_MIN[DW-1:0];
  end

endmodule

// File: rtl/tx_beam_splitter_4.sv
// Transmit beam splitter: one complex sample in, four weighted antenna
// samples out, using a single complex multiplier stepped over the channels.
module tx_beam_splitter_4 #(
  parameter int DW   = bf_pkg::DW,
  parameter int FRAC = bf_pkg::FRAC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] sI,
  input  logic signed [DW-1:0] sQ,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 w_wr_en,
  input  logic [1:0]           w_addr,
  input  logic signed [DW-1:0] w_wrI,
  input  logic signed [DW-1:0] w_wrQ,
  output logic signed [DW-1:0] x1I,
  output logic signed [DW-1:0] x2I,
  output logic signed [DW-1:0] x3I,
  output logic signed [DW-1:0] x4I,
  output logic signed [DW-1:0] x1Q,
  output logic signed [DW-1:0] x2Q,
  output logic signed [DW-1:0] x3Q,
  output logic signed [DW-1:0] x4Q,
  output logic                 x_valid
);

  import bf_pkg::*;

  // Largest positive Q1.(DW-1) value: the reset weight, just under unity.
  localparam logic signed [DW-1:0] W_UNITY = {1'b0, {(DW - 1){1'b1}}};

  bf_state_e state_q, state_d;
  logic signed [DW-1:0] s_i_q, s_i_d, s_q_q, s_q_d;
  logic signed [DW-1:0] sh_i_q[4], sh_i_d[4], sh_q_q[4], sh_q_d[4];
  logic signed [DW-1:0] act_i_q[4], act_i_d[4], act_q_q[4], act_q_d[4];
  logic signed [DW-1:0] x_i_q[4], x_i_d[4], x_q_q[4], x_q_d[4];
  logic [1:0]           ch_sel;
  logic signed [DW-1:0] prod_i, prod_q;

  // Channel currently fed to the multiplier, derived from the sequencing state.
  always_comb begin
    ch_sel = 2'd0;
    case (state_q)
      CH1:     ch_sel = 2'd1;
      CH2:     ch_sel = 2'd2;
      CH3:     ch_sel = 2'd3;
      default: ch_sel = 2'd0;
    endcase
  end

  cmul_sat #(.DW(DW), .FRAC(FRAC)) u_cmul (
    .a_i (act_i_q[ch_sel]),
    .a_q (act_q_q[ch_sel]),
    .b_i (s_i_q),
    .b_q (s_q_q),
    .y_i (prod_i),
    .y_q (prod_q)
  );

  // Next-state logic: shadow weight writes, sample capture and channel stepping.
  always_comb begin
    state_d = state_q;
    s_i_d   = s_i_q;
    s_q_d   = s_q_q;
    sh_i_d  = sh_i_q;
    sh_q_d  = sh_q_q;
    act_i_d = act_i_q;
    act_q_d = act_q_q;
    x_i_d   = x_i_q;
    x_q_d   = x_q_q;

    // The shadow bank is always writable; the active bank only changes on
    // sample capture, and it takes the pre-edge shadow contents.
    if (w_wr_en) begin
      sh_i_d[w_addr] = w_wrI;
      sh_q_d[w_addr] = w_wrQ;
    end

    case (state_q)
      IDLE: begin
        if (s_valid) begin
          s_i_d   = sI;
          s_q_d   = sQ;
          act_i_d = sh_i_q;
          act_q_d = sh_q_q;
          state_d = CH0;
        end
      end
      CH0, CH1, CH2, CH3: begin
        x_i_d[ch_sel] = prod_i;
        x_q_d[ch_sel] = prod_q;
        case (state_q)
          CH0:     state_d = CH1;
          CH1:     state_d = CH2;
          CH2:     state_d = CH3;
          default: state_d = DONE;
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset wins over any concurrent weight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_i_q   <= '0;
      s_q_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        sh_i_q[i]  <= W_UNITY;
        sh_q_q[i]  <= '0;
        act_i_q[i] <= W_UNITY;
        act_q_q[i] <= '0;
        x_i_q[i]   <= '0;
        x_q_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      s_i_q   <= s_i_d;
      s_q_q   <= s_q_d;
      sh_i_q  <= sh_i_d;
      sh_q_q  <= sh_q_d;
      act_i_q <= act_i_d;
      act_q_q <= act_q_d;
      x_i_q   <= x_i_d;
      x_q_q   <= x_q_d;
    end
  end

  assign s_ready = (state_q == IDLE);
  assign x_valid = (state_q == DONE);

  assign x1I = x_i_q[0];
  assign x2I = x_i_q[1];
  assign x3I = x_i_q[2];
  assign x4I = x_i_q[3];
  assign x1Q = x_q_q[0];
  assign x2Q = x_q_q[1];
  assign x3Q = x_q_q[2];
  assign x4Q = x_q_q[3];

endmodule

// File: tb/tb_tx_beam_splitter_4.sv
// Bench for tx_beam_splitter_4: directed scenarios plus random samples and
// weight writes, checked against a plain-arithmetic model of the splitter.
module tb_tx_beam_splitter_4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [17:0] s_i = '0, s_q = '0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic w_wr_en = 1'b0;
  logic [1:0] w_addr = '0;
  logic signed [17:0] w_wr_i = '0, w_wr_q = '0;
  logic signed [17:0] x1I, x2I, x3I, x4I, x1Q, x2Q, x3Q, x4Q;
  logic x_valid;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_hs = -100;
  int txn = 0;

  // Model state: weights the next sample will pick up, and weights in use.
  int sh_i[4], sh_q[4], act_i[4], act_q[4];

  tx_beam_splitter_4 dut (
    .clk(clk), .rst(rst),
    .sI(s_i), .sQ(s_q), .s_valid(s_valid), .s_ready(s_ready),
    .w_wr_en(w_wr_en), .w_addr(w_addr), .w_wrI(w_wr_i), .w_wrQ(w_wr_q),
    .x1I(x1I), .x2I(x2I), .x3I(x3I), .x4I(x4I),
    .x1Q(x1Q), .x2Q(x2Q), .x3Q(x3Q), .x4Q(x4Q),
    .x_valid(x_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Q1.17 product: exact value, floor division by 2^17, clamp to 18-bit range.
  function automatic longint scale_sat(input longint v);
    longint r;
    r = v >>> 17;
    if (r > 131071) r = 131071;
    else if (r < -131072) r = -131072;
    return r;
  endfunction

  function automatic longint get_xi(input int k);
    case (k)
      0: return longint'(x1I);
      1: return longint'(x2I);
      2: return longint'(x3I);
      default: return longint'(x4I);
    endcase
  endfunction

  function automatic longint get_xq(input int k);
    case (k)
      0: return longint'(x1Q);
      1: return longint'(x2Q);
      2: return longint'(x3Q);
      default: return longint'(x4Q);
    endcase
  endfunction

  function automatic int rand_val();
    logic signed [17:0] t;
    t = 18'($urandom);
    case ($urandom_range(5, 0))
      0: return -131072;
      1: return 131071;
      default: return int'(t);
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      sh_i[k] = 131071; sh_q[k] = 0;
      act_i[k] = 131071; act_q[k] = 0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_x%0dI", tag, k + 1), get_xi(k), 0);
      check($sformatf("%s_x%0dQ", tag, k + 1), get_xq(k), 0);
    end
  endtask

  task automatic wr(input int a, input int wi, input int wq);
    w_wr_en = 1'b1; w_addr = 2'(a); w_wr_i = 18'(wi); w_wr_q = 18'(wq);
    tick();
    w_wr_en = 1'b0;
    sh_i[a] = wi; sh_q[a] = wq;
  endtask

  // One sample through the splitter. Optional weight write on the handshake
  // edge (sw), random weight writes while busy (rnd_w), s_valid left high
  // afterwards (hold) and handshake spacing check (chk_gap).
  task automatic send(input int si, input int sq, input bit hold, input bit chk_gap,
                      input bit sw, input int wa, input int wi, input int wq,
                      input bit rnd_w);
    int waited;
    int hs_edge;
    longint ei[4], eq[4];
    bit pend;
    int pa, pi, pq;
    waited = 0;
    s_i = 18'(si); s_q = 18'(sq); s_valid = 1'b1;
    while (!s_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!s_ready) begin
      check("s_ready_timeout", 0, 1);
      s_valid = 1'b0;
      return;
    end
    if (sw) begin
      w_wr_en = 1'b1; w_addr = 2'(wa); w_wr_i = 18'(wi); w_wr_q = 18'(wq);
    end
    for (int k = 0; k < 4; k++) begin
      act_i[k] = sh_i[k];
      act_q[k] = sh_q[k];
    end
    if (sw) begin
      sh_i[wa] = wi; sh_q[wa] = wq;
    end
    for (int k = 0; k < 4; k++) begin
      ei[k] = scale_sat(longint'(act_i[k]) * si - longint'(act_q[k]) * sq);
      eq[k] = scale_sat(longint'(act_i[k]) * sq + longint'(act_q[k]) * si);
    end
    hs_edge = cyc + 1;
    if (chk_gap) check("hs_gap", hs_edge - last_hs, 6);
    last_hs = hs_edge;
    tick();
    w_wr_en = 1'b0;
    if (!hold) s_valid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      pend = 1'b0;
      if (rnd_w && n < 4 && $urandom_range(1, 0) == 1) begin
        pend = 1'b1;
        pa = int'($urandom_range(3, 0)); pi = rand_val(); pq = rand_val();
        w_wr_en = 1'b1; w_addr = 2'(pa); w_wr_i = 18'(pi); w_wr_q = 18'(pq);
      end
      tick();
      w_wr_en = 1'b0;
      if (pend) begin
        sh_i[pa] = pi; sh_q[pa] = pq;
      end
      check($sformatf("x_valid_edge%0d", n), longint'(x_valid), (n == 4) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("x%0dI", k + 1), get_xi(k), ei[k]);
      check($sformatf("x%0dQ", k + 1), get_xq(k), eq[k]);
    end
    $display("txn %0d: s=(%0d,%0d) x1=(%0d,%0d) x2=(%0d,%0d) x3=(%0d,%0d) x4=(%0d,%0d)",
             txn, si, sq, x1I, x1Q, x2I, x2Q, x3I, x3Q, x4I, x4Q);
    txn++;
    tick();
    check("x_valid_pulse", longint'(x_valid), 0);
    check("s_ready_back", longint'(s_ready), 1);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_s_ready", longint'(s_ready), 1);
    check("rst_x_valid", longint'(x_valid), 0);
    check_outputs_zero("rst");
    rst = 1'b0;
    tick();

    // Reset weights, no writes.
    send(65536, -32768, 0, 0, 0, 0, 0, 0, 0);

    // Channel 1 weight j*0.5.
    wr(0, 0, 65536);
    send(65536, 0, 0, 0, 0, 0, 0, 0, 0);

    // Channel 3 weight -1 times sample -1 saturates.
    wr(2, -131072, 0);
    send(-131072, 0, 0, 0, 0, 0, 0, 0, 0);

    // Weight write on the handshake edge applies only from the next sample.
    send(1000, -2000, 0, 0, 1, 1, 0, 0, 0);
    send(1000, -2000, 0, 0, 0, 0, 0, 0, 0);

    // Reset during CH2 (with a weight write on the same edge) aborts cleanly.
    s_i = 18'(12345); s_q = 18'(-777); s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    check("mid_x_valid", longint'(x_valid), 0);
    rst = 1'b1;
    w_wr_en = 1'b1; w_addr = 2'd3; w_wr_i = 18'(5); w_wr_q = 18'(5);
    tick();
    rst = 1'b0;
    w_wr_en = 1'b0;
    model_reset();
    check("abort_s_ready", longint'(s_ready), 1);
    check("abort_x_valid", longint'(x_valid), 0);
    check_outputs_zero("abort");
    for (int n = 0; n < 4; n++) begin
      tick();
      check("abort_no_pulse", longint'(x_valid), 0);
    end
    send(-40000, 70000, 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back samples with s_valid held high.
    for (int n = 0; n < 3; n++) begin
      send(1000 * (n + 1), -3000 * (n + 1), 1, (n > 0), 0, 0, 0, 0, 0);
    end
    s_valid = 1'b0;

    // Random samples and weight traffic.
    for (int n = 0; n < 25; n++) begin
      int cnt;
      cnt = int'($urandom_range(2, 0));
      for (int m = 0; m < cnt; m++) wr(int'($urandom_range(3, 0)), rand_val(), rand_val());
      send(rand_val(), rand_val(), 0, 0, bit'($urandom_range(1, 0)),
           int'($urandom_range(3, 0)), rand_val(), rand_val(), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
